gbsha_ttfir_pipe: RTL and testbench

GBSHA_TTFIR_PIPE -- requirements
Module: gbsha_ttfir_pipe

---
 rtl/gbsha_ttfir_pipe.sv | 162 ++++++++++++++++
 tb/tb_gbsha_ttfir_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gbsha_ttfir_pipe.sv
// Pipelined transposed-load FIR: coefficients are shifted in through x_in in LOAD,
// then samples stream through a delay line with registered products and sum.
module gbsha_ttfir_pipe #(
    parameter int N_TAPS = 8,
    parameter int BW_in  = 6,
    parameter int BW_out = 8,
    parameter int SHIFT  = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [BW_in-1:0]  x_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     coef_load,
    input  logic                     sat_en,
    input  logic                     two_beat,
    output logic [BW_out-1:0]        y_out,
    output logic                     y_valid,
    output logic                     dbg_state_o
);
    localparam int PW = 2 * BW_in;
    localparam int CW = $clog2(N_TAPS);
    localparam int SW = PW + CW;
    localparam int XW = SW + 2 * BW_out;
    localparam logic signed [XW-1:0] Y_MAX = XW'((2 ** (BW_out - 1)) - 1);
    localparam logic signed [XW-1:0] Y_MIN = -Y_MAX - XW'(1);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t                   state_q;
    logic [CW-1:0]            cnt_q;
    logic                     in_ready_q;
    logic signed [BW_in-1:0]  coef_q [N_TAPS];
    logic signed [BW_in-1:0]  x_q    [N_TAPS];
    logic signed [BW_in-1:0]  x_d    [N_TAPS];
    logic signed [PW-1:0]     prod_q [N_TAPS];
    logic                     p_vld_q, p_sat_q, p_two_q;
    logic signed [SW-1:0]     sum_d, sum_q;
    logic                     s_vld_q, s_sat_q, s_two_q;
    logic signed [SW-1:0]     s_shift;
    logic signed [XW-1:0]     s_ext;
    logic [BW_out-1:0]        y_sat, y_q, lo_q;
    logic                     y_valid_q, lo_pend_q;
    logic                     accept, run_acc;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready never depends combinationally on in_valid.
    assign accept  = in_valid && in_ready_q;
    assign run_acc = (state_q == S_RUN) && accept && !coef_load;

    always_comb begin
        x_d[0] = x_in;
        for (int k = 1; k < N_TAPS; k++) x_d[k] = x_q[k-1];
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < N_TAPS; k++) sum_d = sum_d + SW'(prod_q[k]);
    end

    assign s_shift = sum_q >>> SHIFT;
    assign s_ext   = XW'(s_shift);
    assign y_sat   = (s_ext > Y_MAX) ? Y_MAX[BW_out-1:0] :
                     (s_ext < Y_MIN) ? Y_MIN[BW_out-1:0] : s_ext[BW_out-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            for (int k = 0; k < N_TAPS; k++) begin
                coef_q[k] <= '0;
                x_q[k]    <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (coef_load) begin
                        cnt_q <= '0;
                    end else if (accept) begin
                        coef_q[0] <= x_in;
                        for (int k = 1; k < N_TAPS; k++) coef_q[k] <= coef_q[k-1];
                        if (cnt_q == CW'(N_TAPS - 1)) begin
                            state_q <= S_RUN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (coef_load) begin
                        state_q    <= S_LOAD;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        for (int k = 0; k < N_TAPS; k++) x_q[k] <= '0;
                    end else if (accept) begin
                        for (int k = 0; k < N_TAPS; k++) x_q[k] <= x_d[k];
                        in_ready_q <= !two_beat;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // Products see the delay line as it will be after this edge, so the new
    // sample contributes and the output lands two edges after acceptance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p_vld_q   <= 1'b0;
            p_sat_q   <= 1'b0;
            p_two_q   <= 1'b0;
            s_vld_q   <= 1'b0;
            s_sat_q   <= 1'b0;
            s_two_q   <= 1'b0;
            sum_q     <= '0;
            y_q       <= '0;
            lo_q      <= '0;
            y_valid_q <= 1'b0;
            lo_pend_q <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) prod_q[k] <= '0;
        end else begin
            p_vld_q <= run_acc;
            if (run_acc) begin
                for (int k = 0; k < N_TAPS; k++) prod_q[k] <= PW'(x_d[k]) * PW'(coef_q[k]);
                p_sat_q <= sat_en;
                p_two_q <= two_beat;
            end
            s_vld_q <= p_vld_q;
            if (p_vld_q) begin
                sum_q   <= sum_d;
                s_sat_q <= p_sat_q;
                s_two_q <= p_two_q;
            end
            y_valid_q <= 1'b0;
            if (s_vld_q) begin
                y_valid_q <= 1'b1;
                if (s_two_q) begin
                    y_q       <= s_ext[2*BW_out-1:BW_out];
                    lo_q      <= s_ext[BW_out-1:0];
                    lo_pend_q <= 1'b1;
                end else begin
                    y_q       <= s_sat_q ? y_sat : s_ext[BW_out-1:0];
                    lo_pend_q <= 1'b0;
                end
            end else if (lo_pend_q) begin
                y_q       <= lo_q;
                y_valid_q <= 1'b1;
                lo_pend_q <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign y_out       = y_q;
    assign y_valid     = y_valid_q;
    assign dbg_state_o = (state_q == S_RUN);
endmodule

// File: tb/tb_gbsha_ttfir_pipe.sv
// Directed bench for gbsha_ttfir_pipe: three parameterisations share one stimulus
// bus, with in_valid/coef_load steered to the instance selected by sel.
module tb_gbsha_ttfir_pipe;
    logic              clk;
    logic              reset_n;
    logic signed [5:0] x_in;
    logic              in_valid, coef_load, sat_en, two_beat;
    logic [1:0]        sel;
    logic              iv [3];
    logic              cl [3];
    logic              rdy [3];
    logic              yv [3];
    logic              st [3];
    logic [7:0]        y [3];
    logic [7:0]        e41 [8];
    int                n_chk = 0;
    int                n_pass = 0;

    for (genvar g = 0; g < 3; g++) begin : g_steer
        assign iv[g] = in_valid && (sel == 2'(g));
        assign cl[g] = coef_load && (sel == 2'(g));
    end

    gbsha_ttfir_pipe #(.N_TAPS(4), .BW_in(6), .BW_out(8), .SHIFT(0)) d0 (
        .clk(clk), .reset_n(reset_n), .x_in(x_in), .in_valid(iv[0]), .in_ready(rdy[0]),
        .coef_load(cl[0]), .sat_en(sat_en), .two_beat(two_beat), .y_out(y[0]),
        .y_valid(yv[0]), .dbg_state_o(st[0]));
    gbsha_ttfir_pipe #(.N_TAPS(4), .BW_in(6), .BW_out(8), .SHIFT(2)) d2 (
        .clk(clk), .reset_n(reset_n), .x_in(x_in), .in_valid(iv[1]), .in_ready(rdy[1]),
        .coef_load(cl[1]), .sat_en(sat_en), .two_beat(two_beat), .y_out(y[1]),
        .y_valid(yv[1]), .dbg_state_o(st[1]));
    gbsha_ttfir_pipe #(.N_TAPS(8), .BW_in(6), .BW_out(8), .SHIFT(6)) d8 (
        .clk(clk), .reset_n(reset_n), .x_in(x_in), .in_valid(iv[2]), .in_ready(rdy[2]),
        .coef_load(cl[2]), .sat_en(sat_en), .two_beat(two_beat), .y_out(y[2]),
        .y_valid(yv[2]), .dbg_state_o(st[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x);
        x_in     = 6'(x);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cv(input string tag, input logic v);
        chk({tag, "_vld"}, {7'd0, yv[sel]}, {7'd0, v});
    endtask

    task automatic cy(input string tag, input logic [7:0] ye);
        chk({tag, "_vld"}, {7'd0, yv[sel]}, 8'd1);
        chk({tag, "_y"}, y[sel], ye);
    endtask

    task automatic cst(input string tag, input logic run);
        chk({tag, "_st"}, {7'd0, st[sel]}, {7'd0, run});
    endtask

    task automatic crdy(input string tag, input logic r);
        chk({tag, "_rdy"}, {7'd0, rdy[sel]}, {7'd0, r});
    endtask

    initial begin
        e41 = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd112, 8'd127};
        reset_n = 1'b0; x_in = '0; in_valid = 1'b0; coef_load = 1'b0;
        sat_en = 1'b1; two_beat = 1'b0; sel = 2'd0;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            chk("rst_y", y[sel], 8'd0);
            cv("rst", 1'b0);
            crdy("rst", 1'b1);
            cst("rst", 1'b0);
        end
        reset_n = 1'b1;

        // Load all three instances.
        sel = 2'd0;
        send(1); cv("ld0a", 1'b0);
        send(2); send(3); cst("ld0c", 1'b0); crdy("ld0c", 1'b1);
        send(4); cv("ld0d", 1'b0); cst("ld0d", 1'b1);
        sel = 2'd1;
        for (int i = 0; i < 4; i++) send(31);
        cst("ld1", 1'b1);
        sel = 2'd2;
        for (int i = 0; i < 7; i++) send(-32);
        cst("ld2g", 1'b0);
        send(-32); cst("ld2h", 1'b1);

        // Impulse through coefs 4,3,2,1, two cycles of latency each.
        sel = 2'd0;
        send(1); cv("imp0", 1'b0);
        send(0); cv("imp1", 1'b0);
        send(0); cy("imp_a", 8'd4);
        send(0); cy("imp_b", 8'd3);
        idle();  cy("imp_c", 8'd2);
        idle();  cy("imp_d", 8'd1);
        idle();  cv("imp_e", 1'b0); chk("imp_hold", y[sel], 8'd1);

        // Saturate vs truncate, flag carried per sample.
        sel = 2'd1;
        send(31); send(31);
        send(31); cy("sat_a", 8'd127);
        send(31); cy("sat_b", 8'd127);
        sat_en = 1'b0; send(31); cy("sat_c", 8'd127);
        sat_en = 1'b1; send(31); cy("sat_d", 8'd127);
        sat_en = 1'b0; send(31); cy("trn_e", 8'hC1);
        idle(); cy("sat_f", 8'd127);
        idle(); cy("trn_g", 8'hC1);
        idle(); cv("sat_h", 1'b0);

        // Two-beat: MSB then LSB, in_ready drops after each acceptance.
        sat_en = 1'b1; two_beat = 1'b1;
        send(31); crdy("tb_a", 1'b0); cv("tb_a", 1'b0);
        x_in = 6'sd0; in_valid = 1'b1; tick(); in_valid = 1'b0;
        cv("tb_b", 1'b0); crdy("tb_b", 1'b1);
        send(31); cy("tb_c", 8'h03); crdy("tb_c", 1'b0);
        idle(); cy("tb_d", 8'hC1); crdy("tb_d", 1'b1);
        idle(); cy("tb_e", 8'h03);
        idle(); cy("tb_f", 8'hC1);
        idle(); cv("tb_g", 1'b0); chk("tb_hold", y[sel], 8'hC1);
        two_beat = 1'b0;

        // Negative coefs and samples: ramp up to a saturated steady state.
        sel = 2'd2;
        for (int i = 1; i <= 10; i++) begin
            sat_en = (i != 10);
            send(-32);
            if (i >= 3) cy("neg", e41[i-3]);
        end
        idle(); cy("neg_9", 8'd127);
        idle(); cy("neg_trn", 8'h80);
        idle(); cv("neg_end", 1'b0);
        sat_en = 1'b1;

        // coef_load mid-stream.
        sel = 2'd0;
        send(1); cv("cl_a", 1'b0);
        send(2); cv("cl_b", 1'b0);
        coef_load = 1'b1; x_in = 6'sd5; in_valid = 1'b1; tick();
        coef_load = 1'b0; in_valid = 1'b0;
        cy("cl_c", 8'd4); cst("cl_c", 1'b0);
        idle(); cy("cl_d", 8'd11);
        idle(); cv("cl_e", 1'b0);
        send(9); send(9); cv("cl_f", 1'b0);
        coef_load = 1'b1; tick(); coef_load = 1'b0;
        send(5); send(6); cst("cl_g", 1'b0);
        send(7); cst("cl_h", 1'b0);
        send(8); cst("cl_i", 1'b1); cv("cl_i", 1'b0);
        send(3); cv("cl_j", 1'b0);
        send(0); cv("cl_k", 1'b0);
        send(0); cy("cl_l", 8'd24);
        idle(); cy("cl_m", 8'd21);
        idle(); cy("cl_n", 8'd18);
        idle(); cv("cl_o", 1'b0);

        // Reset during the third coefficient beat.
        coef_load = 1'b1; tick(); coef_load = 1'b0;
        send(7); send(7);
        reset_n = 1'b0; x_in = 6'sd7; in_valid = 1'b1; tick(); in_valid = 1'b0;
        chk("rl_y", y[sel], 8'd0); cv("rl", 1'b0); crdy("rl", 1'b1); cst("rl", 1'b0);
        reset_n = 1'b1;
        send(1); send(1); send(1); cst("rl_b", 1'b0);
        send(2); cst("rl_c", 1'b1);
        send(1); send(0);
        send(0); cy("rl_d", 8'd2);
        send(0); cy("rl_e", 8'd1);
        idle(); cy("rl_f", 8'd1);
        idle(); cy("rl_g", 8'd1);
        idle(); cv("rl_h", 1'b0);

        // Reset drops a pending LSB word and an in-flight result.
        two_beat = 1'b1;
        send(-1); crdy("rd_a", 1'b0);
        idle(); cv("rd_b", 1'b0); crdy("rd_b", 1'b1);
        two_beat = 1'b0;
        send(1); cy("rd_c", 8'hFF);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        cv("rd_d", 1'b0); chk("rd_d_y", y[sel], 8'd0);
        idle(); cv("rd_e", 1'b0);
        idle(); cv("rd_f", 1'b0); chk("rd_f_y", y[sel], 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
